// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin front end for one shared restoring divider.
// Define DIV_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT_CYC cycles.
module div_share_arbiter #(
  parameter int WIDTH       = 16,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_Z,
  output logic             rsp_N,
  output logic             rsp_C,
  output logic             rsp_V,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             op_q;
  logic             id_q;
  logic             gnt0;
  logic             gnt1;
  logic             sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] dz_data;
  logic [WIDTH-1:0] div_res;

`ifdef DIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

  // Ties go to whichever requester was not served last.
  assign gnt0 = (state == IDLE) && req0_valid
             && (!req1_valid || last_grant);
  assign gnt1 = (state == IDLE) && req1_valid
             && (!req0_valid || !last_grant);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign busy       = (state != IDLE);

  assign sel_op  = gnt1 ? req1_op : req0_op;
  assign sel_a   = gnt1 ? req1_a  : req0_a;
  assign sel_b   = gnt1 ? req1_b  : req0_b;
  assign dz_data = sel_op ? sel_a : '1;
  assign div_res = op_q ? div_rem : div_quot;

  function automatic logic [3:0] flags_of(
    input logic [WIDTH-1:0] d,
    input logic             c,
    input logic             v
  );
    return {d == '0, d[WIDTH-1], c, v};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= 1'b0;
      id_q       <= 1'b0;
      div_start  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      {rsp_Z, rsp_N, rsp_C, rsp_V} <= 4'b0;
`ifdef DIV_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      div_start <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_q       <= sel_op;
            id_q       <= gnt1;
            last_grant <= gnt1;
            div_a      <= sel_a;
            div_b      <= sel_b;
            if (sel_b == '0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_id    <= gnt1;
              rsp_data  <= dz_data;
              {rsp_Z, rsp_N, rsp_C, rsp_V}
                <= flags_of(dz_data, 1'b0, 1'b1);
            end else begin
              state     <= ISSUE;
              div_start <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef DIV_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (div_done) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= div_res;
            {rsp_Z, rsp_N, rsp_C, rsp_V}
              <= flags_of(div_res, 1'b0, 1'b0);
          end
`ifdef DIV_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= '0;
            {rsp_Z, rsp_N, rsp_C, rsp_V} <= 4'b1011;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: scoreboard bench with a behavioural divider
// and a round-robin reference model for div_share_arbiter.
module tb_div_share_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_op, req0_ready;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_op, req1_ready;
  logic [15:0] req1_a, req1_b;
  logic        div_start, div_done;
  logic [15:0] div_a, div_b, div_quot, div_rem;
  logic        rsp_valid, rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_Z, rsp_N, rsp_C, rsp_V;
  logic        busy;

  div_share_arbiter #(.WIDTH(16), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_Z(rsp_Z), .rsp_N(rsp_N), .rsp_C(rsp_C), .rsp_V(rsp_V),
    .busy(busy)
  );

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic [3:0]  f;
  } rsp_t;

  rsp_t sb[$];
  int   grants[$];
  int   checks = 0;
  int   errors = 0;

  bit          hang = 0;
  int          fix_lat = 0;
  bit          m_busy = 0, m_last = 1;
  bit          exp_start = 0, exp_dz = 0, in_op = 0;
  bit          prev_gen = 0, gen_done = 0, dact = 0;
  int          dlat = 0;
  logic [15:0] dq = 0, dr = 0, op_a = 0, op_b = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: unsigned divide rules, round-robin fairness.
  function automatic rsp_t model(input logic id, input logic op,
                                 input logic [15:0] a,
                                 input logic [15:0] b,
                                 input bit tmo);
    rsp_t r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    if (b == 16'd0) begin
      r.data = op ? a : 16'hFFFF;
      v = 1'b1;
    end else if (tmo) begin
      r.data = 16'd0;
      c = 1'b1;
      v = 1'b1;
    end else begin
      r.data = op ? (a % b) : (a / b);
    end
    r.id = id;
    r.f  = {r.data == 16'd0, r.data[15], c, v};
    return r;
  endfunction

  always @(negedge clk) begin
    logic g0, g1, gop;
    logic [15:0] ga, gb;
    rsp_t e;
    if (!rst) begin
      sb.delete();
      m_busy = 0; m_last = 1; exp_start = 0; exp_dz = 0;
      in_op = 0; prev_gen = 0; dact = 0;
    end else begin
      if (exp_start || div_start)
        chk("div_start", 32'(div_start), 32'(exp_start));
      if (exp_dz) begin
        chk("dz_rsp_latency", 32'(rsp_valid), 32'd1);
        chk("dz_no_start", 32'(div_start), 32'd0);
      end
      if (prev_gen)
        chk("rsp_latency", 32'(rsp_valid), 32'd1);
      prev_gen = gen_done;
      if (div_start && !hang) begin
        dact = 1;
        dlat = (fix_lat != 0) ? fix_lat : $urandom_range(1, 6);
        dq = (div_b == 0) ? 16'hDEAD : div_a / div_b;
        dr = (div_b == 0) ? 16'hDEAD : div_a % div_b;
      end
      exp_start = 0;
      exp_dz = 0;
      if (in_op) begin
        chk("div_a_stable", 32'(div_a), 32'(op_a));
        chk("div_b_stable", 32'(div_b), 32'(op_b));
      end
      chk("busy", 32'(busy), 32'(m_busy));
      g0 = !m_busy && req0_valid && (!req1_valid || m_last);
      g1 = !m_busy && req1_valid && (!req0_valid || !m_last);
      if (req0_valid || req1_valid || req0_ready || req1_ready)
        chk("ready", 32'({req1_ready, req0_ready}), 32'({g1, g0}));
      if (g0 || g1) begin
        gop = g1 ? req1_op : req0_op;
        ga  = g1 ? req1_a  : req0_a;
        gb  = g1 ? req1_b  : req0_b;
        sb.push_back(model(g1, gop, ga, gb, hang));
        grants.push_back(g1 ? 1 : 0);
        m_busy = 1;
        m_last = g1;
        exp_start = (gb != 0);
        exp_dz = (gb == 0);
        in_op = (gb != 0);
        op_a = ga;
        op_b = gb;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: id %0d data 0x%0h at %0t",
                   rsp_id, rsp_data, $time);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_ZNCV", 32'({rsp_Z, rsp_N, rsp_C, rsp_V}),
              32'(e.f));
        end
        m_busy = 0;
        in_op = 0;
      end
    end
  end

  // Behavioural divider with random latency and stray done pulses.
  initial begin
    div_done = 0;
    div_quot = 0;
    div_rem = 0;
    forever begin
      @(posedge clk);
      #1;
      div_done = 0;
      gen_done = 0;
      if (!rst) begin
        dact = 0;
      end else if (dact) begin
        if (dlat <= 1) begin
          div_done = 1;
          gen_done = 1;
          div_quot = dq;
          div_rem = dr;
          dact = 0;
        end else begin
          dlat--;
        end
      end else if (!busy && $urandom_range(0, 5) == 0) begin
        div_done = 1;
        div_quot = 16'($urandom);
        div_rem = 16'($urandom);
      end
    end
  end

  task automatic set_req(input int id, input logic v, input logic op,
                         input logic [15:0] a, input logic [15:0] b);
    if (id == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic drive(input int id, input int n, input bit rnd,
                       input logic op0, input logic [15:0] a0,
                       input logic [15:0] b0);
    logic op;
    logic [15:0] a, b;
    int t, r;
    for (int k = 0; k < n; k++) begin
      op = op0; a = a0; b = b0;
      if (rnd) begin
        r = $urandom_range(0, 3);
        if (r > 0) begin
          repeat (r) @(posedge clk);
          #1;
        end
        op = 1'($urandom);
        a = 16'($urandom);
        r = $urandom_range(0, 7);
        b = (r == 0) ? 16'd0 :
            (r < 3) ? 16'($urandom_range(1, 15)) : 16'($urandom);
      end
      set_req(id, 1'b1, op, a, b);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!rdy(id) && t < 400);
      if (!rdy(id)) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: req%0d ready 0, expected 1", id);
      end
      @(posedge clk);
      #1;
      set_req(id, 1'b0, op, a, b);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((sb.size() != 0 || m_busy) && t < 500);
    if (sb.size() != 0 || m_busy) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: %0d pending, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int id, input logic op,
                        input logic [15:0] a, input logic [15:0] b);
    drive(id, 1, 1'b0, op, a, b);
    wait_idle();
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!div_start && t < 10);
    chk("start_seen", 32'(div_start), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_flags"}, 32'({rsp_Z, rsp_N, rsp_C, rsp_V}), 32'd0);
    chk({tag, "_div_start"}, 32'(div_start), 32'd0);
    chk({tag, "_div_a"}, 32'(div_a), 32'd0);
    chk({tag, "_div_b"}, 32'(div_b), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t;
    rst = 0;
    set_req(0, 1'b0, 1'b0, 16'd0, 16'd0);
    set_req(1, 1'b0, 1'b0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1;

    // Contention straight out of reset: 0,1,0,1.
    grants.delete();
    fork
      drive(0, 2, 1'b0, 1'b0, 16'd100, 16'd7);
      drive(1, 2, 1'b0, 1'b1, 16'd100, 16'd7);
    join
    wait_idle();
    chk("grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk("grant_order", 32'(grants[i]), 32'(i % 2));

    do_req(0, 1'b0, 16'd100, 16'd7);
    do_req(1, 1'b1, 16'd100, 16'd7);
    do_req(1, 1'b1, 16'd21, 16'd7);
    do_req(0, 1'b0, 16'd5, 16'd0);
    do_req(0, 1'b1, 16'd5, 16'd0);
    do_req(1, 1'b0, 16'hFFFF, 16'd1);
    do_req(1, 1'b0, 16'd3, 16'd9);

    // Reset while waiting on the divider drops the operation.
    hang = 1;
    drive(0, 1, 1'b0, 1'b0, 16'd1000, 16'd3);
    wait_start();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk_zero("midreset");
    @(posedge clk);
    #1;
    rst = 1;
    hang = 0;
    do_req(1, 1'b0, 16'd1000, 16'd3);

`ifdef DIV_TIMEOUT_EN
    hang = 1;
    drive(0, 1, 1'b0, 1'b0, 16'd100, 16'd7);
    wait_start();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid && t < 30);
    chk("timeout_latency", 32'(t), 32'd9);
    hang = 0;
    wait_idle();
    fix_lat = 8;
    do_req(1, 1'b0, 16'd100, 16'd7);
    fix_lat = 0;
`endif

    fork
      drive(0, 60, 1'b1, 1'b0, 16'd0, 16'd0);
      drive(1, 60, 1'b1, 1'b0, 16'd0, 16'd0);
    join
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Arbitrates two requesters (e.g. ALU DIV path and MOD path) onto a single shared 16-bit restoring divider.
- Sequences the divider's start/done handshake and returns quotient or remainder, with Z/N/C/V flags, to the granted requester.
- Sits between the ALU op decode and the divider instance; owns the divider's operand and start inputs.

Parameters:
- WIDTH, 16, operand/result width.
- TIMEOUT_CYC, 40, watchdog limit in WAIT cycles; used only with DIV_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_op  in  1  0 = DIV (quotient), 1 = MOD (remainder).
- req0_a, req0_b  in  WIDTH  dividend, divisor.
- req0_ready  out  1  combinational; high in the cycle req0 is accepted.
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- div_start  out  1  one-cycle start pulse to the divider.
- div_a, div_b  out  WIDTH  latched operands; held stable from ISSUE through WAIT.
- div_done  in  1  divider completion.
- div_quot, div_rem  in  WIDTH  divider results.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  1  index of the requester being answered.
- rsp_data  out  WIDTH  result.
- rsp_Z, rsp_N, rsp_C, rsp_V  out  1  flags.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst low, any time, including mid-operation):
  - State IDLE; all outputs 0; latched operands 0; last_grant = 1, so req0 wins the first tie.
  - Any in-flight operation is dropped with no response.
  - The divider shares rst and aborts too.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered except reqN_ready.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant (round-robin).
  - The grant asserts reqN_ready in the same cycle; op, a, b and id are latched at the clock edge; last_grant is updated.
  - Latched b == 0: skip the divider and go to RESP. Data = all-ones for DIV, a for MOD; V = 1.
  - Otherwise go to ISSUE.
- ISSUE: div_start = 1 for exactly one cycle, then WAIT.
- WAIT:
  - Hold until div_done = 1.
  - On that edge, capture div_quot (DIV) or div_rem (MOD) into rsp_data, then go to RESP.
  - div_done in IDLE, ISSUE or RESP is ignored.
- RESP: rsp_valid = 1 for exactly one cycle with rsp_id, rsp_data and flags; next state IDLE.
- Flags:
  - Z = (rsp_data == 0).
  - N = rsp_data[WIDTH-1].
  - C = 0, except on timeout.
  - V = 1 only for divide-by-zero or timeout.
  - rsp_data and flags hold their values after rsp_valid drops, until the next response.
- No new request is accepted while busy; requesters must hold valid and operands until ready.
- Latency:
  - Accept at edge T; div_start high in cycle T+1.
  - Response strobe in the cycle after the div_done edge.
  - Divide-by-zero: rsp_valid in cycle T+1.
- Back-to-back: the earliest next acceptance is the cycle after RESP.
  - Sustained dual requests alternate 0,1,0,1.
  - A lone requester may be granted repeatedly.
- Operands are unsigned. No sign handling.

Optional Feature:
- DIV_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYC cycles elapse without div_done, go to RESP with rsp_data = 0, C = 1, V = 1, Z = 1.
  - The counter clears on entry to WAIT.
  - div_done arriving in the same cycle as expiry wins, giving a normal response.
- DIV_TIMEOUT_EN undefined:
  - No counter; WAIT lasts indefinitely.
  - C is always 0.

Test Plan:
- Single DIV: req0 op=0, a=100, b=7 → one div_start pulse; rsp_id=0, data=14, Z=0, N=0, C=0, V=0.
- Single MOD: req1 op=1, a=100, b=7 → rsp_id=1, data=2. Second case: a=21, b=7 → data=0, Z=1.
- Divide-by-zero:
  - req0 DIV a=5, b=0 → no div_start; rsp_valid one cycle after accept; data=0xFFFF, N=1, V=1.
  - MOD a=5, b=0 → data=5, V=1.
- Contention: both valid from reset, held for 4 ops → grants 0,1,0,1. Each ready is a single cycle; div_a/div_b are stable during every WAIT.
- Reset mid-WAIT: deassert rst two cycles after div_start → no rsp_valid, busy=0, all outputs 0. The next request completes normally.
- DIV_TIMEOUT_EN with TIMEOUT_CYC=8: never assert div_done → rsp_valid 8 cycles into WAIT; data=0, C=1, V=1, Z=1.
